// File: rtl/i2c_master_reg_seq.sv
// Register-access sequencer: expands one host register read/write request into
// the byte-controller command sequence and reports completion and errors.
`timescale 1ns/1ps
module i2c_master_reg_seq #(
   parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        rst,
   input  logic        req,
   input  logic        req_rnw,
   input  logic [6:0]  dev_addr,
   input  logic [7:0]  reg_addr,
   input  logic [1:0]  len,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] rd_data,
   output logic        err_nack,
   output logic        err_al,
   output logic        err_timeout,
   output logic        bc_rst,
   output logic        bc_start,
   output logic        bc_stop,
   output logic        bc_read,
   output logic        bc_write,
   output logic        bc_ack_in,
   output logic [7:0]  bc_din,
   input  logic        bc_cmd_ack,
   input  logic        bc_ack_out,
   input  logic [7:0]  bc_dout,
   input  logic        bc_al
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEV_W,
      ST_REG,
      ST_WDATA,
      ST_RSTART,
      ST_RDATA,
      ST_STOP,
      ST_DONE
   } state_t;

   state_t      state_reg, state_next;
   logic        rnw_reg, rnw_next;
   logic [6:0]  dev_reg, dev_next;
   logic [7:0]  regaddr_reg, regaddr_next;
   logic [1:0]  len_reg, len_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [1:0]  k_reg, k_next;
   logic [15:0] timer_reg, timer_next;
   logic        active_reg, active_next;
   logic        start_reg, start_next;
   logic        stop_reg, stop_next;
   logic        read_reg, read_next;
   logic        write_reg, write_next;
   logic        ack_in_reg, ack_in_next;
   logic [7:0]  din_reg, din_next;
   logic        err_nack_reg, err_nack_next;
   logic        err_al_reg, err_al_next;
   logic        err_to_reg, err_to_next;
   logic        bc_rst_reg, bc_rst_next;
   logic [7:0]  rd_byte_reg [4];
   logic [7:0]  rd_byte_next [4];
   logic [7:0]  wr_byte [4];

   logic last_byte;
   logic timeout_hit;
   logic nack_seen;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bytes
         assign wr_byte[gi]           = wdata_reg[8*gi +: 8];
         assign rd_data[8*gi +: 8]    = rd_byte_reg[gi];
      end
   endgenerate

   assign last_byte   = (k_reg == len_reg);
   // The wait counter fires on the edge where it would reach TIMEOUT_CYC.
   assign timeout_hit = (TIMEOUT_CYC != 16'd0) && (timer_reg == TIMEOUT_CYC - 16'd1);
   assign nack_seen   = write_reg && bc_ack_out;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_reg    <= ST_IDLE;
         rnw_reg      <= 1'b0;
         dev_reg      <= '0;
         regaddr_reg  <= '0;
         len_reg      <= '0;
         wdata_reg    <= '0;
         k_reg        <= '0;
         timer_reg    <= '0;
         active_reg   <= 1'b0;
         start_reg    <= 1'b0;
         stop_reg     <= 1'b0;
         read_reg     <= 1'b0;
         write_reg    <= 1'b0;
         ack_in_reg   <= 1'b0;
         din_reg      <= '0;
         err_nack_reg <= 1'b0;
         err_al_reg   <= 1'b0;
         err_to_reg   <= 1'b0;
         bc_rst_reg   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            rd_byte_reg[i] <= '0;
         end
      end else begin
         state_reg    <= state_next;
         rnw_reg      <= rnw_next;
         dev_reg      <= dev_next;
         regaddr_reg  <= regaddr_next;
         len_reg      <= len_next;
         wdata_reg    <= wdata_next;
         k_reg        <= k_next;
         timer_reg    <= timer_next;
         active_reg   <= active_next;
         start_reg    <= start_next;
         stop_reg     <= stop_next;
         read_reg     <= read_next;
         write_reg    <= write_next;
         ack_in_reg   <= ack_in_next;
         din_reg      <= din_next;
         err_nack_reg <= err_nack_next;
         err_al_reg   <= err_al_next;
         err_to_reg   <= err_to_next;
         bc_rst_reg   <= bc_rst_next;
         rd_byte_reg  <= rd_byte_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rnw_next      = rnw_reg;
      dev_next      = dev_reg;
      regaddr_next  = regaddr_reg;
      len_next      = len_reg;
      wdata_next    = wdata_reg;
      k_next        = k_reg;
      timer_next    = timer_reg;
      active_next   = active_reg;
      start_next    = start_reg;
      stop_next     = stop_reg;
      read_next     = read_reg;
      write_next    = write_reg;
      ack_in_next   = ack_in_reg;
      din_next      = din_reg;
      err_nack_next = err_nack_reg;
      err_al_next   = err_al_reg;
      err_to_next   = err_to_reg;
      bc_rst_next   = 1'b0;
      rd_byte_next  = rd_byte_reg;

      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               rnw_next      = req_rnw;
               dev_next      = dev_addr;
               regaddr_next  = reg_addr;
               len_next      = len;
               wdata_next    = wr_data;
               k_next        = 2'd0;
               err_nack_next = 1'b0;
               err_al_next   = 1'b0;
               err_to_next   = 1'b0;
               for (int i = 0; i < 4; i++) begin
                  rd_byte_next[i] = '0;
               end
               state_next    = ST_DEV_W;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            if (bc_al) begin
               // The byte controller drops to idle on its own, so no STOP follows.
               start_next  = 1'b0;
               stop_next   = 1'b0;
               read_next   = 1'b0;
               write_next  = 1'b0;
               ack_in_next = 1'b0;
               active_next = 1'b0;
               err_al_next = 1'b1;
               state_next  = ST_DONE;
            end else if (!active_reg) begin
               active_next = 1'b1;
               timer_next  = 16'd0;
               start_next  = 1'b0;
               stop_next   = 1'b0;
               read_next   = 1'b0;
               write_next  = 1'b0;
               ack_in_next = 1'b0;
               din_next    = 8'h00;
               case (state_reg)
                  ST_DEV_W: begin
                     start_next = 1'b1;
                     write_next = 1'b1;
                     din_next   = {dev_reg, 1'b0};
                  end
                  ST_REG: begin
                     write_next = 1'b1;
                     din_next   = regaddr_reg;
                  end
                  ST_WDATA: begin
                     write_next = 1'b1;
                     stop_next  = last_byte;
                     din_next   = wr_byte[k_reg];
                  end
                  ST_RSTART: begin
                     start_next = 1'b1;
                     write_next = 1'b1;
                     din_next   = {dev_reg, 1'b1};
                  end
                  ST_RDATA: begin
                     read_next   = 1'b1;
                     ack_in_next = last_byte;
                     stop_next   = last_byte;
                  end
                  default: begin
                     stop_next = 1'b1;
                  end
               endcase
            end else if (timeout_hit) begin
               start_next  = 1'b0;
               stop_next   = 1'b0;
               read_next   = 1'b0;
               write_next  = 1'b0;
               ack_in_next = 1'b0;
               active_next = 1'b0;
               err_to_next = 1'b1;
               bc_rst_next = 1'b1;
               state_next  = ST_DONE;
            end else if (bc_cmd_ack) begin
               start_next  = 1'b0;
               stop_next   = 1'b0;
               read_next   = 1'b0;
               write_next  = 1'b0;
               ack_in_next = 1'b0;
               active_next = 1'b0;
               if (nack_seen) begin
                  err_nack_next = 1'b1;
                  state_next    = stop_reg ? ST_DONE : ST_STOP;
               end else begin
                  case (state_reg)
                     ST_DEV_W: state_next = ST_REG;
                     ST_REG: begin
                        k_next     = 2'd0;
                        state_next = rnw_reg ? ST_RSTART : ST_WDATA;
                     end
                     ST_WDATA: begin
                        if (last_byte) state_next = ST_DONE;
                        else           k_next     = k_reg + 2'd1;
                     end
                     ST_RSTART: begin
                        k_next     = 2'd0;
                        state_next = ST_RDATA;
                     end
                     ST_RDATA: begin
                        rd_byte_next[k_reg] = bc_dout;
                        if (last_byte) state_next = ST_DONE;
                        else           k_next     = k_reg + 2'd1;
                     end
                     default: state_next = ST_DONE;
                  endcase
               end
            end else begin
               timer_next = timer_reg + 16'd1;
            end
         end
      endcase

      if (rst) begin
         state_next    = ST_IDLE;
         rnw_next      = 1'b0;
         dev_next      = '0;
         regaddr_next  = '0;
         len_next      = '0;
         wdata_next    = '0;
         k_next        = '0;
         timer_next    = '0;
         active_next   = 1'b0;
         start_next    = 1'b0;
         stop_next     = 1'b0;
         read_next     = 1'b0;
         write_next    = 1'b0;
         ack_in_next   = 1'b0;
         din_next      = '0;
         err_nack_next = 1'b0;
         err_al_next   = 1'b0;
         err_to_next   = 1'b0;
         bc_rst_next   = 1'b0;
         for (int i = 0; i < 4; i++) begin
            rd_byte_next[i] = '0;
         end
      end
   end

   assign busy        = (state_reg != ST_IDLE);
   assign done        = (state_reg == ST_DONE);
   assign err_nack    = err_nack_reg;
   assign err_al      = err_al_reg;
   assign err_timeout = err_to_reg;
   assign bc_rst      = bc_rst_reg;
   assign bc_start    = start_reg;
   assign bc_stop     = stop_reg;
   assign bc_read     = read_reg;
   assign bc_write    = write_reg;
   assign bc_ack_in   = ack_in_reg;
   assign bc_din      = din_reg;

endmodule

// File: doc/i2c_master_reg_seq.md
Name: i2c_master_reg_seq

Overview:
- Register-access transaction sequencer directly upstream of the I2C master byte controller.
- Turns one host request into the full byte-command sequence for a register write or register read of 1-4 data bytes:
  - START + device address
  - register address
  - data, or a repeated START and read data
  - STOP
- Drives the byte controller's start/stop/read/write/ack_in/din command inputs and consumes cmd_ack/ack_out/dout/i2c_al.
- Reports completion and NACK / arbitration-lost / timeout errors to the host.

Parameters:
- TIMEOUT_CYC, 16'hFFFF: maximum clk cycles one byte command may wait for bc_cmd_ack before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- Reset  in  1  reset, asynchronous, active-high
- rst  in  1  synchronous active-high reset; same effect as Reset
- req  in  1  host request; sampled only in IDLE
- req_rnw  in  1  1 = register read, 0 = register write
- dev_addr  in  7  7-bit slave address
- reg_addr  in  8  register address
- len  in  2  data byte count minus 1 (0..3 = 1..4 bytes)
- wr_data  in  32  write data; byte i = wr_data[8i+7:8i]; byte 0 is sent first
- busy  out  1  high from request acceptance until the done pulse, inclusive
- done  out  1  one-cycle completion pulse
- rd_data  out  32  read data; byte i received is placed in [8i+7:8i]
- err_nack  out  1  slave NACKed a write byte
- err_al  out  1  arbitration lost
- err_timeout  out  1  command not acknowledged within TIMEOUT_CYC
- bc_rst  out  1  one-cycle synchronous reset pulse to the byte controller
- bc_start, bc_stop, bc_read, bc_write  out  1 each  byte-controller command bits
- bc_ack_in  out  1  ACK value to send after a read byte (1 = NACK)
- bc_din  out  8  byte to transmit
- bc_cmd_ack  in  1  byte-controller command-complete pulse
- bc_ack_out  in  1  received ACK bit (1 = NACK)
- bc_dout  in  8  received byte
- bc_al  in  1  arbitration lost

Behaviour:
- Reset (Reset or rst):
  - All outputs 0; rd_data = 0; state IDLE; internal counters 0.
  - rst is subordinate to Reset. Reset mid-transaction aborts immediately with no done pulse.
- Request acceptance:
  - In IDLE, req=1 captures req_rnw, dev_addr, reg_addr, len and wr_data; busy rises the next cycle.
  - req outside IDLE is ignored.
  - err_* and rd_data clear on acceptance; otherwise they hold until the next acceptance.
- Command handshake:
  - Command bits, bc_din and bc_ack_in are registered and held stable until the cycle bc_cmd_ack=1.
  - At that edge all command bits clear; the next command is issued no earlier than the following cycle.
  - Each command is a single handshake and gets exactly one bc_cmd_ack.
- States and commands issued:
  - IDLE
  - DEV_W: start=1, write=1, din={dev_addr,1'b0}.
  - REG: write=1, din=reg_addr.
  - WDATA (write requests only): write=1, din=byte k; stop=1 on the last byte (k=len).
  - RSTART (read requests only): start=1, write=1, din={dev_addr,1'b1}.
  - RDATA: read=1, ack_in=0 for k<len; on k=len, ack_in=1 and stop=1. At bc_cmd_ack, bc_dout is stored into byte k.
  - STOP: stop=1 only.
  - DONE: done=1 for one cycle, busy deasserts the same edge, then IDLE.
- Transitions:
  - DEV_W -> REG.
  - Write request: REG -> WDATA; WDATA loops k=0..len, then -> DONE.
  - Read request: REG -> RSTART -> RDATA; RDATA loops k=0..len, then -> DONE.
  - Byte counter k is 2 bits, reset to 0 on entering WDATA or RDATA.
- NACK handling:
  - At bc_cmd_ack of any write-type command with bc_ack_out=1: set err_nack.
  - If that command carried stop, go to DONE; otherwise go to STOP, then DONE.
- Arbitration lost:
  - bc_al=1 in any non-IDLE state: clear all command bits, set err_al, go to DONE.
  - No STOP is issued, because the byte controller self-resets to idle.
  - bc_al has priority over a simultaneous bc_cmd_ack.
- Timeout:
  - A 16-bit counter clears on each command issue and increments while waiting for bc_cmd_ack.
  - On reaching TIMEOUT_CYC: clear command bits, set err_timeout, pulse bc_rst for one cycle, go to DONE.
  - bc_al has priority over timeout; timeout has priority over bc_cmd_ack in the same cycle.
- At most one err_* is set per transaction; exception: err_nack may be followed by err_al or err_timeout during the STOP state.

Test Plan:
- Write, dev=0x50, reg=0x10, len=1, wr_data=0x0000BEEF, all ACK:
  - din sequence 0xA0 (start+write), 0x10, 0xEF, 0xBE (stop+write).
  - done pulse with all err_*=0; exactly 4 handshakes.
- Read, dev=0x50, reg=0x20, len=2, slave returns 0x11, 0x22, 0x33:
  - din 0xA0, 0x20, then 0xA1 with start.
  - Three reads with ack_in 0, 0, 1; stop on the last read.
  - rd_data = 0x00332211.
- Write len=3 with slave NACK on REG:
  - err_nack=1; stop-only command issued; WDATA never entered; done pulse; busy low afterwards.
- bc_al asserted during the second RDATA byte:
  - Command bits drop the next cycle; err_al=1; no stop issued; done pulse.
- TIMEOUT_CYC=20, bc_cmd_ack never returned for DEV_W:
  - bc_rst pulses once 20 cycles after issue; err_timeout=1; done pulse.
- req held high through an entire transaction, with Reset asserted mid-REG:
  - Only one transaction per IDLE visit.
  - Reset immediately clears all outputs with no done pulse.
  - After release, a new req is accepted.
